image_streamer: RTL and testbench

IMAGE_STREAMER -- requirements
Module: image_streamer

---
 rtl/image_streamer.sv | 122 ++++++++++++
 tb/tb_image_streamer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/image_streamer.sv
// Buffers an img_size x img_size signed image written by the host and streams it
// row-major with a zero border of width pad, one word per cycle after a start pulse.
module image_streamer #(
    parameter int dwidth   = 16,
    parameter int img_size = 28,
    parameter int pad      = 1,
    parameter int awidth   = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [awidth-1:0]        wr_addr,
    input  logic signed [dwidth-1:0] wr_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     dout_st,
    output logic signed [dwidth-1:0] dout
);

    localparam int P    = img_size + 2 * pad;
    localparam int NPIX = img_size * img_size;
    localparam int CW   = (P > 2) ? $clog2(P) : 1;

    localparam logic [CW-1:0]     PAD_C  = CW'(pad);
    localparam logic [CW-1:0]     END_C  = CW'(pad + img_size);
    localparam logic [CW-1:0]     LAST_C = CW'(P - 1);
    localparam logic [awidth:0]   NPIX_C = (awidth + 1)'(NPIX);
    localparam logic [awidth-1:0] IMG_C  = awidth'(img_size);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    logic signed [dwidth-1:0] mem [NPIX];
    logic signed [dwidth-1:0] mem_rd_q;

    state_t                   state_q, state_d;
    logic [CW-1:0]            row_q, row_d, col_q, col_d;
    logic                     v1_q, v1_d, st1_q, st1_d, zero1_q, zero1_d;
    logic                     busy_q, busy_d, done_q, done_d, dout_st_q, dout_st_d;
    logic signed [dwidth-1:0] dout_q, dout_d;

    logic                     wr_ok, rd_en, in_img, streaming;
    logic [awidth-1:0]        rd_addr;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        streaming = (state_q == STREAM);
        wr_ok     = wr_en && !busy_q && ({1'b0, wr_addr} < NPIX_C);
        in_img    = (row_q >= PAD_C) && (row_q < END_C) && (col_q >= PAD_C) && (col_q < END_C);
        rd_en     = streaming && in_img;
        rd_addr   = awidth'(row_q - PAD_C) * IMG_C + awidth'(col_q - PAD_C);

        // Stage 1 tracks the issued position alongside the synchronous buffer read
        v1_d    = streaming;
        st1_d   = streaming && (row_q == '0) && (col_q == '0);
        zero1_d = !in_img;

        case (state_q)
            IDLE: begin
                row_d = '0;
                col_d = '0;
                if (start && !busy_q) state_d = STREAM;
            end
            STREAM: begin
                if (col_q == LAST_C) begin
                    col_d = '0;
                    if (row_q == LAST_C) state_d = FLUSH;
                    else                 row_d   = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // busy covers the two pipeline stages still draining after the FSM returns to IDLE
        busy_d    = (state_d != IDLE) || v1_d || v1_q;
        done_d    = busy_q && !busy_d;
        dout_d    = (v1_q && !zero1_q) ? mem_rd_q : '0;
        dout_st_d = st1_q;
    end

    always_ff @(posedge clk) begin
        if (wr_ok)      mem[wr_addr] <= wr_data;
        else if (rd_en) mem_rd_q     <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            v1_q      <= 1'b0;
            st1_q     <= 1'b0;
            zero1_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_st_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            v1_q      <= v1_d;
            st1_q     <= st1_d;
            zero1_q   <= zero1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dout_st_q <= dout_st_d;
            dout_q    <= dout_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign dout_st = dout_st_q;
    assign dout    = dout_q;

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer: expected stream words are queued from a
// reference image model at start and popped as each word appears on dout.
module tb_image_streamer;

    localparam int DW   = 16;
    localparam int IMG  = 28;
    localparam int PAD  = 1;
    localparam int AW   = 10;
    localparam int P    = IMG + 2 * PAD;
    localparam int NW   = P * P;
    localparam int NPIX = IMG * IMG;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 wr_en = 1'b0;
    logic                 start = 1'b0;
    logic [AW-1:0]        wr_addr = '0;
    logic signed [DW-1:0] wr_data = '0;
    logic                 busy, done, dout_st;
    logic signed [DW-1:0] dout;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] model_mem [NPIX];
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    image_streamer #(
        .dwidth  (DW),
        .img_size(IMG),
        .pad     (PAD),
        .awidth  (AW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .dout_st(dout_st),
        .dout   (dout)
    );

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] exp_word(input int n);
        int r, c;
        r = n / P;
        c = n % P;
        if (r < PAD || r >= PAD + IMG || c < PAD || c >= PAD + IMG) return 16'h0000;
        return model_mem[(r - PAD) * IMG + (c - PAD)];
    endfunction

    task automatic write_px(input int addr, input logic [15:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (addr < NPIX) model_mem[addr] = data;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, {15'b0, busy}, 16'h0000);
        chk({tag, "_done"}, {15'b0, done}, 16'h0000);
        chk({tag, "_st"}, {15'b0, dout_st}, 16'h0000);
        chk({tag, "_dout"}, dout, 16'h0000);
    endtask

    // prestarted: start was already raised in the previous done cycle.
    // chain: raise start in this stream's done cycle. Negative indices disable injections.
    task automatic run_stream(input bit prestarted, input bit chain, input int abort_at,
                              input int inj_s1, input int inj_s2, input int inj_w);
        logic [15:0] e;
        if (!prestarted) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        for (int n = 0; n < NW; n++) exp_q.push_back(exp_word(n));

        @(negedge clk);
        chk("lat0_busy", {15'b0, busy}, 16'h0001);
        chk("lat0_st", {15'b0, dout_st}, 16'h0000);
        chk("lat0_dout", dout, 16'h0000);
        chk("lat0_done", {15'b0, done}, 16'h0000);
        @(negedge clk);
        chk("lat1_busy", {15'b0, busy}, 16'h0001);
        chk("lat1_st", {15'b0, dout_st}, 16'h0000);
        chk("lat1_dout", dout, 16'h0000);

        for (int n = 0; n < NW; n++) begin
            @(negedge clk);
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_idle("abort");
                exp_q.delete();
                repeat (3) @(negedge clk);
                check_idle("held_rst");
                rst_n = 1'b1;
                return;
            end
            e = exp_q.pop_front();
            chk($sformatf("word%0d", n), dout, e);
            chk($sformatf("st%0d", n), {15'b0, dout_st}, (n == 0) ? 16'h0001 : 16'h0000);
            chk($sformatf("busy%0d", n), {15'b0, busy}, 16'h0001);
            chk($sformatf("done%0d", n), {15'b0, done}, 16'h0000);
            start = (n == inj_s1 || n == inj_s2);
            if (n == inj_w) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = 16'h1234;
            end else begin
                wr_en = 1'b0;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;

        @(negedge clk);
        chk("done_pulse", {15'b0, done}, 16'h0001);
        chk("done_busy", {15'b0, busy}, 16'h0000);
        chk("done_dout", dout, 16'h0000);
        chk("done_st", {15'b0, dout_st}, 16'h0000);
        chk("queue_empty", 16'(exp_q.size()), 16'h0000);
        if (chain) begin
            start = 1'b1;
        end else begin
            @(negedge clk);
            chk("done_drop", {15'b0, done}, 16'h0000);
            chk("idle_busy", {15'b0, busy}, 16'h0000);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // Ramp image: mem[i] = i + 1
        for (int i = 0; i < NPIX; i++) write_px(i, 16'(i + 1));
        check_idle("after_load");
        run_stream(1'b0, 1'b0, -1, -1, -1, -1);

        // Signed extremes; mem[0] written in the same cycle the stream starts
        write_px(NPIX - 1, 16'h7FFF);
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 16'hFFFB;
        model_mem[0] = 16'hFFFB;
        run_stream(1'b0, 1'b0, -1, -1, -1, -1);

        // Starts and a write during a stream are ignored; next stream starts in the done cycle
        run_stream(1'b0, 1'b1, -1, 10, 400, 200);
        run_stream(1'b1, 1'b0, -1, -1, -1, -1);

        // Out-of-range write has no effect
        write_px(NPIX, 16'hAAAA);
        run_stream(1'b0, 1'b0, -1, -1, -1, -1);

        // Reset mid-stream, buffer survives
        run_stream(1'b0, 1'b0, 450, -1, -1, -1);
        check_idle("post_abort");
        run_stream(1'b0, 1'b0, -1, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
